// File: rtl/hazard_bubble_unit.sv
// Load-use hazard detector with a registered ID/EX control bundle.
// Holds the front end for LOAD_STALL cycles per hazard, injects bubbles, and squashes on flush.
module hazard_bubble_unit #(
  parameter int unsigned        CTRL_W      = 8,
  parameter int unsigned        REG_AW      = 5,
  parameter int unsigned        MEMREAD_BIT = 1,
  parameter int unsigned        LOAD_STALL  = 1,
  parameter logic [CTRL_W-1:0]  BUBBLE      = '0,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              stall_active,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // A single-cycle stall never leaves IDLE; longer stalls count the remaining bubbles in STALL.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);
  localparam logic [0:0] HAZARD_NEXT  = (LOAD_STALL == 1) ? ST_IDLE : ST_STALL;

  logic [0:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic hazard;
  logic hold;
  logic bubble_inc;
  logic rs1_match;
  logic rs2_match;

  assign rs1_match = (ex_rd == id_rs1);
  assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);

  assign hazard = (state_q == ST_IDLE) && ex_ctrl_q[MEMREAD_BIT] &&
                  (ex_rd != '0) && (rs1_match || rs2_match);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_ctrl_d  = id_ctrl;
    hold       = 1'b0;
    bubble_inc = 1'b0;

    if (flush) begin
      ex_ctrl_d = BUBBLE;
      state_d   = ST_IDLE;
      cnt_d     = '0;
    end else if (state_q == ST_STALL) begin
      hold       = 1'b1;
      bubble_inc = 1'b1;
      ex_ctrl_d  = BUBBLE;
      cnt_d      = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = ST_IDLE;
      end
    end else if (hazard) begin
      hold       = 1'b1;
      bubble_inc = 1'b1;
      ex_ctrl_d  = BUBBLE;
      state_d    = HAZARD_NEXT;
      cnt_d      = STALL_RELOAD;
    end
  end

  // Saturating: once all-ones the count sticks rather than wrapping.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_inc && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ex_ctrl_q    <= BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_ctrl_q    <= ex_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // The front end always runs while reset is asserted.
  assign pc_write     = ~(rst_n & hold);
  assign ifid_write   = ~(rst_n & hold);
  assign stall_active = rst_n & hold;
  assign ex_ctrl      = ex_ctrl_q;
  assign bubble_cnt   = bubble_cnt_q;

endmodule
